// File: rtl/tx_link_sched.sv
// tx_link_sched: transmit link scheduler in front of the 8b10b serializer.
// Shares one serial lane between NREQ packet sources using round-robin
// arbitration with packet lock, sends a K28.5 alignment preamble after reset,
// fills idle slots with K28.5 and forces a sync comma between packets when
// SYNC_PERIOD-1 slots have passed without one. Paced by the serializer's
// symbol-load strobe; every ser_ena_i=1 cycle is one slot.
//
// Ports
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   req_valid_i  per-requester symbol valid
//   req_data_i   per-requester symbol {K,data[7:0]}, requester i at [9i+8:9i]
//   req_last_i   per-requester last symbol of packet
//   req_ready_o  per-requester accept (combinational, only in a slot)
//   ser_ena_i    serializer load strobe, one cycle = one slot
//   ser_data_o   symbol held for the serializer
//   grant_o      one-hot owner of the packet in flight, 0 when none
//   link_up_o    alignment preamble complete
//   busy_o       packet in flight
//   underrun_o   one-cycle pulse when the owner is not valid in a mid-packet slot
module tx_link_sched #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned ALIGN_LEN   = 16,
  parameter int unsigned SYNC_PERIOD = 256
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NREQ-1:0]     req_valid_i,
  input  logic [NREQ*9-1:0]   req_data_i,
  input  logic [NREQ-1:0]     req_last_i,
  output logic [NREQ-1:0]     req_ready_o,
  input  logic                ser_ena_i,
  output logic [8:0]          ser_data_o,
  output logic [NREQ-1:0]     grant_o,
  output logic                link_up_o,
  output logic                busy_o,
  output logic                underrun_o
);

  localparam int unsigned SYM_W  = 9;
  localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned ACNT_W = $clog2(ALIGN_LEN + 1);
  localparam int unsigned SCNT_W = $clog2(SYNC_PERIOD);

  localparam logic [SYM_W-1:0]  K28_5      = 9'h1BC;
  localparam logic [ACNT_W-1:0] ALIGN_LAST = ACNT_W'(ALIGN_LEN - 1);
  localparam logic [SCNT_W-1:0] SYNC_MAX   = SCNT_W'(SYNC_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_ALIGN = 2'd0,
    ST_ARB   = 2'd1,
    ST_PKT   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYM_W-1:0]  sym_q, sym_d;
  logic [ACNT_W-1:0] align_cnt_q;
  logic [SCNT_W-1:0] sync_cnt_q;
  logic [IDX_W-1:0]  rr_ptr_q, rr_d;
  logic              rr_upd;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              link_up_q;
  logic              underrun_q, underrun_d;
  logic [NREQ-1:0]   ready_c;

  logic              arb_found;
  logic [IDX_W-1:0]  arb_idx;
  logic [IDX_W-1:0]  cand;
  logic              sync_hit;

  logic [SYM_W-1:0]  req_sym [NREQ];

  // Unpack the flat data bus into one symbol per requester.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_sym[g] = req_data_i[SYM_W*g +: SYM_W];
  end

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return IDX_W'((32'(i) + 32'd1) % NREQ);
  endfunction

  // Round-robin search: first valid requester starting at rr_ptr.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDX_W'((32'(rr_ptr_q) + k) % NREQ);
      if (!arb_found && req_valid_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // A sync comma is due once the lane has gone SYNC_PERIOD-1 slots without one.
  assign sync_hit = (sync_cnt_q >= SYNC_MAX);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_ALIGN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; transitions happen only in slots.
  always_comb begin
    state_d = state_q;
    if (ser_ena_i) begin
      case (state_q)
        ST_ALIGN: begin
          if (align_cnt_q == ALIGN_LAST) state_d = ST_ARB;
        end
        ST_ARB: begin
          if (!sync_hit && arb_found && !req_last_i[arb_idx]) state_d = ST_PKT;
        end
        ST_PKT: begin
          if (req_valid_i[owner_q] && req_last_i[owner_q]) state_d = ST_ARB;
        end
        default: state_d = ST_ALIGN;
      endcase
    end
  end

  // Output/datapath decisions for the current slot.
  always_comb begin
    ready_c    = '0;
    sym_d      = K28_5;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_d       = rr_ptr_q;
    rr_upd     = 1'b0;
    underrun_d = 1'b0;
    case (state_q)
      ST_ALIGN: begin
        sym_d = K28_5;
      end
      ST_ARB: begin
        if (sync_hit) begin
          sym_d = K28_5;
        end else if (arb_found) begin
          ready_c[arb_idx] = 1'b1;
          sym_d            = req_sym[arb_idx];
          if (req_last_i[arb_idx]) begin
            // Single-symbol packet: no lock, just advance the pointer.
            rr_d   = next_idx(arb_idx);
            rr_upd = 1'b1;
          end else begin
            owner_d          = arb_idx;
            grant_d          = '0;
            grant_d[arb_idx] = 1'b1;
          end
        end
      end
      ST_PKT: begin
        ready_c[owner_q] = 1'b1;
        if (req_valid_i[owner_q]) begin
          sym_d = req_sym[owner_q];
          if (req_last_i[owner_q]) begin
            rr_d    = next_idx(owner_q);
            rr_upd  = 1'b1;
            grant_d = '0;
          end
        end else begin
          // Owner starved mid-packet: hold the lock, send filler.
          sym_d      = K28_5;
          underrun_d = 1'b1;
        end
      end
      default: begin
        sym_d = K28_5;
      end
    endcase
  end

  // Ready only in a slot and never while reset is asserted.
  assign req_ready_o = (ser_ena_i && !rst_i) ? ready_c : '0;

  // Datapath registers: updated only in slots, except the underrun clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sym_q       <= K28_5;
      align_cnt_q <= '0;
      sync_cnt_q  <= '0;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      grant_q     <= '0;
      link_up_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      if (ser_ena_i) begin
        sym_q      <= sym_d;
        grant_q    <= grant_d;
        owner_q    <= owner_d;
        underrun_q <= underrun_d;
        if (rr_upd) rr_ptr_q <= rr_d;
        // Any comma on the lane, including one sent by a requester, restarts the count.
        if (sym_d == K28_5) begin
          sync_cnt_q <= '0;
        end else if (sync_cnt_q != SYNC_MAX) begin
          sync_cnt_q <= sync_cnt_q + SCNT_W'(1);
        end
        if (state_q == ST_ALIGN) begin
          align_cnt_q <= align_cnt_q + ACNT_W'(1);
          if (align_cnt_q == ALIGN_LAST) link_up_q <= 1'b1;
        end
      end
    end
  end

  assign ser_data_o = sym_q;
  assign grant_o    = grant_q;
  assign link_up_o  = link_up_q;
  assign busy_o     = (state_q == ST_PKT);
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_tx_link_sched.sv
// Directed bench for tx_link_sched (NREQ=4, ALIGN_LEN=16, SYNC_PERIOD=8).
module tb_tx_link_sched;

  localparam int unsigned NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*9-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              ser_ena;
  logic [8:0]        ser_data;
  logic [NREQ-1:0]   grant;
  logic              link_up;
  logic              busy;
  logic              underrun;

  logic [8:0] rd [NREQ];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[9*i +: 9] = rd[i];
  end

  tx_link_sched #(
    .NREQ       (NREQ),
    .ALIGN_LEN  (16),
    .SYNC_PERIOD(8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_data_i (req_data),
    .req_last_i (req_last),
    .req_ready_o(req_ready),
    .ser_ena_i  (ser_ena),
    .ser_data_o (ser_data),
    .grant_o    (grant),
    .link_up_o  (link_up),
    .busy_o     (busy),
    .underrun_o (underrun)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One slot: ready checked before the edge, loaded symbol/grant/underrun after it.
  task automatic slot(input string tag, input logic [3:0] er, input logic [8:0] es,
                      input logic [3:0] eg, input logic eu, input int gap,
                      output logic [3:0] rdy);
    @(negedge clk);
    ser_ena = 1'b1;
    #1;
    rdy = req_ready;
    check({tag, ".ready"}, 16'(req_ready), 16'(er));
    @(posedge clk);
    #1;
    ser_ena = 1'b0;
    check({tag, ".sym"}, 16'(ser_data), 16'(es));
    check({tag, ".grant"}, 16'(grant), 16'(eg));
    check({tag, ".busy"}, 16'(busy), 16'(eg != 4'b0));
    check({tag, ".underrun"}, 16'(underrun), 16'(eu));
    repeat (gap) @(posedge clk);
    #1;
  endtask

  logic [8:0] t3_sym [11] = '{9'h050, 9'h051, 9'h060, 9'h061, 9'h070, 9'h071,
                              9'h040, 9'h041, 9'h1BC, 9'h052, 9'h053};
  logic [3:0] t3_rdy [11] = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000,
                              4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010};
  logic [3:0] t3_gnt [11] = '{4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000,
                              4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000};

  initial begin
    logic [3:0] rdy;
    int unsigned cnt [NREQ];
    int unsigned n;

    rst = 1'b1;
    ser_ena = 1'b0;
    req_valid = '0;
    req_last = '0;
    for (int i = 0; i < NREQ; i++) begin
      rd[i] = '0;
      cnt[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst.sym", 16'(ser_data), 16'h1BC);
    check("rst.grant", 16'(grant), 16'h0);
    check("rst.link_up", 16'(link_up), 16'h0);
    check("rst.busy", 16'(busy), 16'h0);
    check("rst.underrun", 16'(underrun), 16'h0);
    check("rst.ready", 16'(req_ready), 16'h0);
    rst = 1'b0;

    // Test 1: preamble with a slot every 10 cycles, then idle fill.
    for (int i = 0; i < 16; i++) begin
      slot($sformatf("t1.align%0d", i), 4'b0, 9'h1BC, 4'b0, 1'b0, 9, rdy);
      check($sformatf("t1.link_up%0d", i), 16'(link_up), 16'(i == 15));
    end
    slot("t1.idle0", 4'b0, 9'h1BC, 4'b0, 1'b0, 9, rdy);
    slot("t1.idle1", 4'b0, 9'h1BC, 4'b0, 1'b0, 9, rdy);
    check("t1.link_held", 16'(link_up), 16'h1);

    // Test 2: req0 3-symbol packet.
    req_valid = 4'b0001;
    rd[0] = 9'h011; req_last = 4'b0000;
    slot("t2.s0", 4'b0001, 9'h011, 4'b0001, 1'b0, 2, rdy);
    rd[0] = 9'h022;
    slot("t2.s1", 4'b0001, 9'h022, 4'b0001, 1'b0, 2, rdy);
    rd[0] = 9'h033; req_last = 4'b0001;
    slot("t2.s2", 4'b0001, 9'h033, 4'b0000, 1'b0, 2, rdy);
    req_valid = '0; req_last = '0;
    slot("t2.idle", 4'b0000, 9'h1BC, 4'b0000, 1'b0, 2, rdy);

    // Test 3: all requesters stream 2-symbol packets; sync comma lands between packets.
    for (int s = 0; s < 11; s++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = 1'b1;
        rd[i] = 9'(32'h040 + 32'(16 * i) + cnt[i]);
        req_last[i] = ((cnt[i] % 2) == 1);
      end
      slot($sformatf("t3.s%0d", s), t3_rdy[s], t3_sym[s], t3_gnt[s], 1'b0, 1, rdy);
      for (int i = 0; i < NREQ; i++) if (rdy[i]) cnt[i]++;
    end
    req_valid = '0; req_last = '0;

    // Test 4: owner req2 stalls two slots; req3 stays blocked until the packet ends.
    req_valid = 4'b1100; req_last = 4'b1000;
    rd[2] = 9'h0A1; rd[3] = 9'h0F3;
    slot("t4.s0", 4'b0100, 9'h0A1, 4'b0100, 1'b0, 1, rdy);
    req_valid = 4'b1000;
    slot("t4.s1", 4'b0100, 9'h1BC, 4'b0100, 1'b1, 0, rdy);
    slot("t4.s2", 4'b0100, 9'h1BC, 4'b0100, 1'b1, 1, rdy);
    check("t4.underrun_clr", 16'(underrun), 16'h0);
    req_valid = 4'b1100; rd[2] = 9'h0A2;
    slot("t4.s3", 4'b0100, 9'h0A2, 4'b0100, 1'b0, 1, rdy);
    rd[2] = 9'h0A3; req_last = 4'b1100;
    slot("t4.s4", 4'b0100, 9'h0A3, 4'b0000, 1'b0, 1, rdy);
    req_valid = 4'b1000; req_last = 4'b1000;
    slot("t4.s5", 4'b1000, 9'h0F3, 4'b0000, 1'b0, 1, rdy);
    req_valid = '0; req_last = '0;

    // Test 5: req1 single-symbol stream, back-to-back slots, comma every 8th slot.
    slot("t5.idle", 4'b0000, 9'h1BC, 4'b0000, 1'b0, 0, rdy);
    n = 0;
    req_valid = 4'b0010; req_last = 4'b0010;
    for (int k = 1; k <= 16; k++) begin
      rd[1] = 9'(32'h0C0 + n);
      if ((k % 8) == 0) begin
        slot($sformatf("t5.k%0d", k), 4'b0000, 9'h1BC, 4'b0000, 1'b0, 0, rdy);
      end else begin
        slot($sformatf("t5.k%0d", k), 4'b0010, 9'(32'h0C0 + n), 4'b0000, 1'b0, 0, rdy);
        n++;
      end
    end
    req_valid = '0; req_last = '0;
    repeat (2) @(posedge clk);
    #1;

    // Test 6: reset in the middle of a req2 packet.
    req_valid = 4'b0100; rd[2] = 9'h0B1;
    slot("t6.s0", 4'b0100, 9'h0B1, 4'b0100, 1'b0, 1, rdy);
    rd[2] = 9'h0B2;
    @(negedge clk);
    rst = 1'b1;
    ser_ena = 1'b1;
    #1;
    check("t6.rst_ready", 16'(req_ready), 16'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ser_ena = 1'b0;
    check("t6.rst_sym", 16'(ser_data), 16'h1BC);
    check("t6.rst_grant", 16'(grant), 16'h0);
    check("t6.rst_busy", 16'(busy), 16'h0);
    check("t6.rst_link", 16'(link_up), 16'h0);
    for (int i = 0; i < 16; i++) begin
      slot($sformatf("t6.align%0d", i), 4'b0, 9'h1BC, 4'b0, 1'b0, 1, rdy);
      check($sformatf("t6.link_up%0d", i), 16'(link_up), 16'(i == 15));
    end
    slot("t6.s1", 4'b0100, 9'h0B2, 4'b0100, 1'b0, 1, rdy);
    rd[2] = 9'h0B3; req_last = 4'b0100;
    slot("t6.s2", 4'b0100, 9'h0B3, 4'b0000, 1'b0, 1, rdy);
    req_valid = '0; req_last = '0;
    slot("t6.idle", 4'b0000, 9'h1BC, 4'b0000, 1'b0, 1, rdy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
